user_input_sampler: RTL

Input-side counterpart of the LED driver: conditions the board push buttons and slide switches and delivers clean user events to the game core. It synchronizes and debounces every raw input. On a confirmed press of the enter key it captures the debounced switch word as the user's symbol and emits a one-cycle strobe. A separate restart key produces a one-cycle restart request.

---
 rtl/game_pkg.sv | 14 +
 rtl/input_debouncer.sv | 47 ++++
 rtl/user_input_sampler.sv | 113 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: default widths/timing and the enter-key FSM state type.
// Used by the input sampler, the LED driver and the game core.
package game_pkg;

    localparam int SYMBOL_W_DEF        = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CAPTURE      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } enter_state_e;

endpackage

// File: rtl/input_debouncer.sv
// One-bit 2-FF synchronizer followed by a debounce counter; the output only
// follows a new level after it has been seen for DEBOUNCE_CYCLES synchronized cycles.
module input_debouncer
    import game_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize the raw level and accept it once it has held long enough.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_meta   <= RESET_VAL;
            r_sync   <= RESET_VAL;
            r_stable <= RESET_VAL;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/user_input_sampler.sv
// Debounces switches and keys, captures the switch word once per enter press
// and produces a one-cycle restart request on each restart press.
module user_input_sampler
    import game_pkg::*;
#(
    parameter int SYMBOL_W        = SYMBOL_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                s_rst_i,
    input  logic [SYMBOL_W-1:0] switches_i,
    input  logic                key_enter_n_i,
    input  logic                key_restart_n_i,
    output logic [SYMBOL_W-1:0] user_symbol_o,
    output logic                user_symbol_valid_o,
    output logic                restart_o
);

    localparam int NUM_IN = SYMBOL_W + 2;

    logic [NUM_IN-1:0]   w_raw;
    logic [NUM_IN-1:0]   w_deb;
    logic [SYMBOL_W-1:0] w_switches;
    logic                w_enter;
    logic                w_restart;

    enter_state_e        r_state;
    enter_state_e        w_state_nxt;

    logic [SYMBOL_W-1:0] r_symbol;
    logic                r_valid;
    logic                r_restart_d;
    logic                r_restart;

    assign w_raw = {key_restart_n_i, key_enter_n_i, switches_i};

    // Keys idle high, so their debouncers reset to 1 (released).
    for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       ((g >= SYMBOL_W) ? 1'b1 : 1'b0)
        ) u_deb (
            .i_clk    (clk_i),
            .i_srst   (s_rst_i),
            .i_raw    (w_raw[g]),
            .o_stable (w_deb[g])
        );
    end

    assign w_switches = w_deb[SYMBOL_W-1:0];
    assign w_enter    = ~w_deb[SYMBOL_W];
    assign w_restart  = ~w_deb[SYMBOL_W+1];

    // Enter FSM state register.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enter FSM next-state logic: one capture per press, then wait for release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_enter) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (w_enter) begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers: symbol capture, valid strobe and restart edge detect.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_symbol    <= {SYMBOL_W{1'b0}};
            r_valid     <= 1'b0;
            r_restart_d <= 1'b0;
            r_restart   <= 1'b0;
        end else begin
            r_valid     <= (w_state_nxt == ST_CAPTURE);
            if (w_state_nxt == ST_CAPTURE) begin
                r_symbol <= w_switches;
            end else begin
                r_symbol <= r_symbol;
            end
            r_restart_d <= w_restart;
            r_restart   <= w_restart & ~r_restart_d;
        end
    end

    assign user_symbol_o       = r_symbol;
    assign user_symbol_valid_o = r_valid;
    assign restart_o           = r_restart;

endmodule
